// File: rtl/seq_pkg.sv
// seq_pkg: shared constants for the next-PC controller -- jump condition
// codes, sequencer FSM states and status-flag bit positions.
package seq_pkg;

    // Jump condition codes carried on jmp_cond; 10..15 are reserved and never taken.
    localparam logic [3:0] JC_NONE = 4'd0;
    localparam logic [3:0] JC_JMP  = 4'd1;
    localparam logic [3:0] JC_JEQ  = 4'd2;
    localparam logic [3:0] JC_JNE  = 4'd3;
    localparam logic [3:0] JC_JGT  = 4'd4;
    localparam logic [3:0] JC_JLT  = 4'd5;
    localparam logic [3:0] JC_JGE  = 4'd6;
    localparam logic [3:0] JC_JLE  = 4'd7;
    localparam logic [3:0] JC_JCR  = 4'd8;
    localparam logic [3:0] JC_JOV  = 4'd9;

    // Sequencer states: HALTED and FAULT are only left through reset.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } state_t;

    // Bit positions inside the {Z,N,C,V} status register.
    localparam int F_Z = 3;
    localparam int F_N = 2;
    localparam int F_C = 1;
    localparam int F_V = 0;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// ret_stack: LIFO of return addresses. sp counts occupancy (0..DEPTH); the
// storage index is sp modulo DEPTH, so an overflowing push overwrites the
// oldest entry and an underflowing pop reads a stale one. Callers that must
// not wrap simply withhold push/pop when full/empty.
module ret_stack
    import seq_pkg::*;
#(
    parameter int AW    = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [AW-1:0]            din,
    output logic [AW-1:0]            dout,
    output logic [$clog2(DEPTH):0]   sp,
    output logic                     full,
    output logic                     empty
);

    localparam int IW  = $clog2(DEPTH);
    localparam int SPW = IW + 1;

    logic [AW-1:0] mem [DEPTH];
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;

    assign wr_idx = sp[IW-1:0];
    assign rd_idx = wr_idx - 1'b1;
    assign full   = (sp == SPW'(DEPTH));
    assign empty  = (sp == '0);
    // Read is combinational so a RET completes in a single cycle.
    assign dout   = mem[rd_idx];

    // Store the return address at the current top-of-stack slot.
    always_ff @(posedge clk) begin
        if (push && !pop) begin
            mem[wr_idx] <= din;
        end
    end

    // Occupancy counter; wraps modulo DEPTH on overflow/underflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp <= '0;
        end else if (pop) begin
            sp <= empty ? SPW'(DEPTH - 1) : sp - 1'b1;
        end else if (push) begin
            sp <= full ? SPW'(1) : sp + 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter, the {Z,N,C,V} status register,
// conditional/unconditional jumps and the CALL/RET return stack.
// Optional feature: define PC_STACK_GUARD_EN to trap stack overflow/underflow
// (sticky stack_err, transfer suppressed, FSM -> FAULT). Without it the stack
// pointer wraps and stack_err stays 0.
module pc_sequencer
    import seq_pkg::*;
#(
    parameter int AW          = 8,
    parameter int STACK_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall,
    input  logic                           halt,
    input  logic                           flag_we,
    input  logic                           alu_z,
    input  logic                           alu_n,
    input  logic                           alu_c,
    input  logic                           alu_v,
    input  logic [3:0]                     jmp_cond,
    input  logic [AW-1:0]                  jmp_target,
    input  logic                           call,
    input  logic                           ret,
    output logic [AW-1:0]                  pc,
    output logic [3:0]                     flags,
    output logic [$clog2(STACK_DEPTH):0]   sp,
    output logic                           halted,
    output logic                           stack_err
);

    // Jump decision from the registered flags; reserved codes fall to default.
    function automatic logic cond_taken(input logic [3:0] jc, input logic [3:0] f);
        logic t;
        t = 1'b0;
        case (jc)
            JC_JMP:  t = 1'b1;
            JC_JEQ:  t = f[F_Z];
            JC_JNE:  t = !f[F_Z];
            JC_JGT:  t = !f[F_N] && !f[F_Z];
            JC_JLT:  t = f[F_N];
            JC_JGE:  t = !f[F_N];
            JC_JLE:  t = f[F_N] || f[F_Z];
            JC_JCR:  t = f[F_C];
            JC_JOV:  t = f[F_V];
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    state_t        state_reg;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] stack_top;
    logic          stack_full;
    logic          stack_empty;
    logic          advance;
    logic          guard_err;
    logic          push;
    logic          pop;

    assign pc_inc  = pc + 1'b1;
    // A control transfer can happen only when running, not stalled and not halting.
    assign advance = (state_reg == ST_RUN) && !stall && !halt;

`ifdef PC_STACK_GUARD_EN
    // RET on an empty stack, or a CALL (not overridden by RET) on a full one.
    assign guard_err = advance && ((ret && stack_empty) || (call && !ret && stack_full));
`else
    assign guard_err = 1'b0;
    logic unused_stack_status;
    assign unused_stack_status = stack_full ^ stack_empty;
`endif

    assign pop  = advance && ret && !guard_err;
    assign push = advance && call && !ret && !guard_err;

    ret_stack #(
        .AW    (AW),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (stack_top),
        .sp    (sp),
        .full  (stack_full),
        .empty (stack_empty)
    );

    // Sequencer FSM with registered pc, flags, halted and stack_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_RUN;
            pc        <= '0;
            flags     <= 4'h0;
            halted    <= 1'b0;
            stack_err <= 1'b0;
        end else if (state_reg == ST_RUN) begin
            // Flags load even while stalled; jumps this cycle still see the old value.
            if (flag_we) begin
                flags <= {alu_z, alu_n, alu_c, alu_v};
            end
            if (halt) begin
                state_reg <= ST_HALTED;
                halted    <= 1'b1;
            end else if (!stall) begin
                if (guard_err) begin
                    state_reg <= ST_FAULT;
                    halted    <= 1'b1;
                    stack_err <= 1'b1;
                end else if (ret) begin
                    pc <= stack_top;
                end else if (call) begin
                    pc <= jmp_target;
                end else if (cond_taken(jmp_cond, flags)) begin
                    pc <= jmp_target;
                end else begin
                    pc <= pc_inc;
                end
            end
        end
    end

endmodule
